// File: rtl/proc_step_seq_if.sv
// Control/status bundle for the stage sequencer.
// The master drives the instruction controls; the slave (sequencer) drives the stage enables and status.
interface proc_step_seq_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 16
) ();
  localparam int IDX_W = $clog2(NUM_STAGES);

  logic                  start_i;
  logic [NUM_STAGES-1:0] skip_mask_i;
  logic                  stall_i;
  logic                  flush_i;
  logic [NUM_STAGES-1:0] step_o;
  logic [IDX_W-1:0]      stage_idx_o;
  logic                  busy_o;
  logic                  done_o;
  logic [CNT_W-1:0]      instr_count_o;

  modport master (
    output start_i, skip_mask_i, stall_i, flush_i,
    input  step_o, stage_idx_o, busy_o, done_o, instr_count_o
  );

  modport slave (
    input  start_i, skip_mask_i, stall_i, flush_i,
    output step_o, stage_idx_o, busy_o, done_o, instr_count_o
  );
endinterface

// File: rtl/proc_step_seq.sv
// Parametrised one-hot stage sequencer for the multicycle processor.
// Walks fetch..writeback, skipping stages masked per instruction, with stall,
// flush, optional back-to-back restart, a retire pulse and a retired counter.
module proc_step_seq #(
  parameter int NUM_STAGES   = 5,
  parameter int CNT_W        = 16,
  parameter int AUTO_RESTART = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  proc_step_seq_if.slave    bus
);
  localparam int IDX_W = $clog2(NUM_STAGES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [NUM_STAGES-1:0] step_q, step_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Stages above the current one that this instruction still has to visit.
  logic [NUM_STAGES-1:0] avail;
  logic                  nxt_found;
  logic [IDX_W-1:0]      nxt_idx;
  // Fetch is never skippable, so bit 0 of the incoming mask is dropped.
  logic [NUM_STAGES-1:0] new_mask;

  assign new_mask = bus.skip_mask_i & ~NUM_STAGES'(1);
  assign avail[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_STAGES; gi++) begin : g_avail
      assign avail[gi] = ~mask_q[gi] && (IDX_W'(gi) > idx_q);
    end
  endgenerate

  // Pick the lowest-index remaining stage; none left means this is the retire cycle.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = NUM_STAGES - 1; i >= 1; i--) begin
      if (avail[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state and registered-output logic: flush > stall > advance/retire.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          mask_d  = new_mask;
          step_d  = NUM_STAGES'(1);
          idx_d   = '0;
        end
      end
      RUN: begin
        if (bus.flush_i) begin
          state_d = IDLE;
          step_d  = '0;
          idx_d   = '0;
        end else if (bus.stall_i) begin
          // hold everything
        end else if (nxt_found) begin
          step_d = NUM_STAGES'(1) << nxt_idx;
          idx_d  = nxt_idx;
        end else begin
          done_d  = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (bus.start_i || (AUTO_RESTART != 0)) begin
            mask_d = new_mask;
            step_d = NUM_STAGES'(1);
            idx_d  = '0;
          end else begin
            state_d = IDLE;
            step_d  = '0;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        idx_d   = '0;
      end
    endcase
    busy_d = |step_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      step_q  <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign bus.step_o        = step_q;
  assign bus.stage_idx_o   = idx_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.instr_count_o = count_q;
endmodule

// File: tb/tb_proc_step_seq.sv
// Directed scoreboard bench for proc_step_seq: dut_a (CNT_W=4, no auto-restart)
// and dut_b (CNT_W=16, auto-restart). Each vector carries hand-computed outputs.
module tb_proc_step_seq;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  proc_step_seq_if #(.NUM_STAGES(5), .CNT_W(4))  bus_a ();
  proc_step_seq_if #(.NUM_STAGES(5), .CNT_W(16)) bus_b ();

  proc_step_seq #(.NUM_STAGES(5), .CNT_W(4),  .AUTO_RESTART(0)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(bus_a.slave));
  proc_step_seq #(.NUM_STAGES(5), .CNT_W(16), .AUTO_RESTART(1)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(bus_b.slave));

  typedef struct {
    bit          which;   // 0 = dut_a, 1 = dut_b
    logic [4:0]  step;
    logic        done;
    logic [15:0] cnt;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_id   = 0;

  function automatic logic [2:0] idx_of(input logic [4:0] s);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 5; i++) if (s[i]) r = 3'(i);
    return r;
  endfunction

  // Apply one cycle of stimulus to dut_a and queue its expected post-edge outputs.
  task automatic va(input bit r, input bit st, input logic [4:0] m, input bit stl,
                    input bit fl, input logic [4:0] es, input bit ed, input int ec);
    exp_t e;
    @(negedge clk);
    rst_a = r; bus_a.start_i = st; bus_a.skip_mask_i = m;
    bus_a.stall_i = stl; bus_a.flush_i = fl;
    e.which = 1'b0; e.step = es; e.done = ed; e.cnt = 16'(ec); e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Same for dut_b.
  task automatic vb(input bit r, input bit st, input logic [4:0] m, input bit stl,
                    input bit fl, input logic [4:0] es, input bit ed, input int ec);
    exp_t e;
    @(negedge clk);
    rst_b = r; bus_b.start_i = st; bus_b.skip_mask_i = m;
    bus_b.stall_i = stl; bus_b.flush_i = fl;
    e.which = 1'b1; e.step = es; e.done = ed; e.cnt = 16'(ec); e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: one comparison per cycle whenever an expectation is pending.
  initial begin
    exp_t        e;
    logic [25:0] act, req;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.which == 1'b0)
          act = {bus_a.step_o, bus_a.stage_idx_o, bus_a.busy_o, bus_a.done_o, 12'd0, bus_a.instr_count_o};
        else
          act = {bus_b.step_o, bus_b.stage_idx_o, bus_b.busy_o, bus_b.done_o, bus_b.instr_count_o};
        req = {e.step, idx_of(e.step), |e.step, e.done, e.cnt};
        n_checks++;
        if (act === req) begin
          n_pass++;
          $display("vec %0d dut_%s step=%b idx=%0d busy=%b done=%b cnt=%0d ok",
                   e.id, e.which ? "b" : "a", act[25:21], act[20:18], act[17], act[16], act[15:0]);
        end else begin
          $display("FAIL vec %0d dut_%s {step,idx,busy,done,cnt}: got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                   e.id, e.which ? "b" : "a",
                   act[25:21], act[20:18], act[17], act[16], act[15:0],
                   req[25:21], req[20:18], req[17], req[16], req[15:0]);
        end
      end
    end
  end

  initial begin
    int budget;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.start_i = 0; bus_a.skip_mask_i = 0; bus_a.stall_i = 0; bus_a.flush_i = 0;
    bus_b.start_i = 0; bus_b.skip_mask_i = 0; bus_b.stall_i = 0; bus_b.flush_i = 0;

    // Reset state
    va(1,0,5'b00000,0,0, 5'b00000,0,0);
    va(1,0,5'b00000,0,0, 5'b00000,0,0);
    // Full 5-stage walk
    va(0,1,5'b00000,0,0, 5'b00001,0,0);
    va(0,0,5'b00000,0,0, 5'b00010,0,0);
    va(0,0,5'b00000,0,0, 5'b00100,0,0);
    va(0,0,5'b00000,0,0, 5'b01000,0,0);
    va(0,0,5'b00000,0,0, 5'b10000,0,0);
    va(0,0,5'b00000,0,0, 5'b00000,1,1);
    va(0,0,5'b00000,0,0, 5'b00000,0,1);
    // Skip mask 01010
    va(0,1,5'b01010,0,0, 5'b00001,0,1);
    va(0,0,5'b00000,0,0, 5'b00100,0,1);
    va(0,0,5'b00000,0,0, 5'b10000,0,1);
    va(0,0,5'b00000,0,0, 5'b00000,1,2);
    va(0,0,5'b00000,0,0, 5'b00000,0,2);
    // Mask 11111: fetch-only, bit 0 ignored
    va(0,1,5'b11111,0,0, 5'b00001,0,2);
    va(0,0,5'b00000,0,0, 5'b00000,1,3);
    va(0,0,5'b00000,0,0, 5'b00000,0,3);
    // Stall ignored in IDLE, then start with stall high still fetches
    va(0,0,5'b00000,1,0, 5'b00000,0,3);
    va(0,1,5'b00000,1,0, 5'b00001,0,3);
    va(0,0,5'b00000,0,0, 5'b00010,0,3);
    va(0,0,5'b00000,0,0, 5'b00100,0,3);
    // Stall 3 cycles in 00100
    va(0,0,5'b00000,1,0, 5'b00100,0,3);
    va(0,0,5'b00000,1,0, 5'b00100,0,3);
    va(0,0,5'b00000,1,0, 5'b00100,0,3);
    va(0,0,5'b00000,0,0, 5'b01000,0,3);
    va(0,0,5'b00000,0,0, 5'b10000,0,3);
    va(0,0,5'b00000,0,0, 5'b00000,1,4);
    // Flush in 01000
    va(0,1,5'b00000,0,0, 5'b00001,0,4);
    va(0,0,5'b00000,0,0, 5'b00010,0,4);
    va(0,0,5'b00000,0,0, 5'b00100,0,4);
    va(0,0,5'b00000,0,0, 5'b01000,0,4);
    va(0,0,5'b00000,0,1, 5'b00000,0,4);
    va(0,0,5'b00000,0,0, 5'b00000,0,4);
    // Flush with start: no new fetch
    va(0,1,5'b00000,0,0, 5'b00001,0,4);
    va(0,1,5'b00000,0,1, 5'b00000,0,4);
    va(0,0,5'b00000,0,0, 5'b00000,0,4);
    // Flush beats stall
    va(0,1,5'b00000,0,0, 5'b00001,0,4);
    va(0,0,5'b00000,0,0, 5'b00010,0,4);
    va(0,0,5'b00000,1,1, 5'b00000,0,4);
    // Stall on the retire cycle (fetch-only) delays done
    va(0,1,5'b11110,0,0, 5'b00001,0,4);
    va(0,0,5'b00000,1,0, 5'b00001,0,4);
    va(0,0,5'b00000,1,0, 5'b00001,0,4);
    va(0,0,5'b00000,0,0, 5'b00000,1,5);
    // Back-to-back with start held; third instruction re-samples mask 00110
    va(0,1,5'b00000,0,0, 5'b00001,0,5);
    va(0,1,5'b00000,0,0, 5'b00010,0,5);
    va(0,1,5'b00000,0,0, 5'b00100,0,5);
    va(0,1,5'b00000,0,0, 5'b01000,0,5);
    va(0,1,5'b00000,0,0, 5'b10000,0,5);
    va(0,1,5'b00000,0,0, 5'b00001,1,6);
    va(0,1,5'b00000,0,0, 5'b00010,0,6);
    va(0,1,5'b00000,0,0, 5'b00100,0,6);
    va(0,1,5'b00000,0,0, 5'b01000,0,6);
    va(0,1,5'b00000,0,0, 5'b10000,0,6);
    va(0,1,5'b00110,0,0, 5'b00001,1,7);
    va(0,0,5'b00000,0,0, 5'b01000,0,7);
    va(0,0,5'b00000,0,0, 5'b10000,0,7);
    va(0,0,5'b00000,0,0, 5'b00000,1,8);
    va(0,0,5'b00000,0,0, 5'b00000,0,8);
    // Counter wrap (4-bit): back-to-back fetch-only instructions
    va(0,1,5'b11111,0,0, 5'b00001,0,8);
    for (int k = 9; k <= 16; k++)
      va(0,1,5'b11111,0,0, 5'b00001,1,k % 16);
    va(0,0,5'b00000,0,0, 5'b00000,1,1);
    // Reset mid-instruction in 00100
    va(0,1,5'b00000,0,0, 5'b00001,0,1);
    va(0,0,5'b00000,0,0, 5'b00010,0,1);
    va(0,0,5'b00000,0,0, 5'b00100,0,1);
    va(1,0,5'b00000,0,0, 5'b00000,0,0);
    va(0,0,5'b00000,0,0, 5'b00000,0,0);

    // Auto-restart instance: one start pulse, continuous 5-cycle loop
    vb(1,0,5'b00000,0,0, 5'b00000,0,0);
    vb(0,1,5'b00000,0,0, 5'b00001,0,0);
    vb(0,0,5'b00000,0,0, 5'b00010,0,0);
    vb(0,0,5'b00000,0,0, 5'b00100,0,0);
    vb(0,0,5'b00000,0,0, 5'b01000,0,0);
    vb(0,0,5'b00000,0,0, 5'b10000,0,0);
    vb(0,0,5'b00000,0,0, 5'b00001,1,1);
    vb(0,0,5'b00000,0,0, 5'b00010,0,1);
    vb(0,0,5'b00000,0,0, 5'b00100,0,1);
    vb(0,0,5'b00000,0,0, 5'b01000,0,1);
    vb(0,0,5'b00000,0,0, 5'b10000,0,1);
    vb(0,0,5'b00000,0,0, 5'b00001,1,2);
    vb(0,0,5'b00000,0,1, 5'b00000,0,2);
    vb(0,0,5'b00000,0,0, 5'b00000,0,2);

    // Drain the scoreboard with a bounded wait.
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
